present_iter: RTL and testbench

Iterative PRESENT block-cipher core: one round per clock, with a full on-chip key schedule and a valid/ready handshake on both sides. It is the parametrised successor to the single combinational round stage. Key width is selectable between PRESENT-80 and PRESENT-128, and decryption can be compiled in. It sits between the message framing logic and the transport buffer of the secure-messaging datapath.

---
 rtl/present_pkg.sv | 85 ++++++++
 rtl/present_iter_if.sv | 39 +++
 rtl/present_key_step.sv | 65 ++++++
 rtl/present_iter.sv | 180 ++++++++++++++++++
 tb/tb_present_iter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared definitions for the iterative PRESENT core: S-box tables, FSM states,
// round-count default and key-width dependent bit positions.
// Optional feature macro: PRESENT_DEC_EN (compiles in the inverse S-box).
package present_pkg;

    // Standard PRESENT runs 31 full rounds; reduced-round builds override this.
    localparam int PRESENT_ROUNDS = 31;

    // Core FSM states. EXPAND and DRUN are only reachable in decrypt builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        EXPAND = 3'd2,
        DRUN   = 3'd3,
        FINAL  = 3'd4,
        HOLD   = 3'd5
    } state_t;

    // Position of the round-counter XOR inside the key register.
    localparam int KEY80_RC_LSB  = 15;
    localparam int KEY128_RC_LSB = 62;

    // Number of top key nibbles passed through the S-box per key step.
    localparam int KEY80_TOP_NIBBLES  = 1;
    localparam int KEY128_TOP_NIBBLES = 2;

    function automatic int rc_lsb(input int key_w);
        return (key_w == 128) ? KEY128_RC_LSB : KEY80_RC_LSB;
    endfunction

    function automatic int top_nibbles(input int key_w);
        return (key_w == 128) ? KEY128_TOP_NIBBLES : KEY80_TOP_NIBBLES;
    endfunction

    // PRESENT 4-bit S-box.
    function automatic logic [3:0] sbox(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'h0: s = 4'hC;
            4'h1: s = 4'h5;
            4'h2: s = 4'h6;
            4'h3: s = 4'hB;
            4'h4: s = 4'h9;
            4'h5: s = 4'h0;
            4'h6: s = 4'hA;
            4'h7: s = 4'hD;
            4'h8: s = 4'h3;
            4'h9: s = 4'hE;
            4'hA: s = 4'hF;
            4'hB: s = 4'h8;
            4'hC: s = 4'h4;
            4'hD: s = 4'h7;
            4'hE: s = 4'h1;
            default: s = 4'h2;
        endcase
        return s;
    endfunction

`ifdef PRESENT_DEC_EN
    // Inverse of the PRESENT S-box.
    function automatic logic [3:0] sbox_inv(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'h0: s = 4'h5;
            4'h1: s = 4'hE;
            4'h2: s = 4'hF;
            4'h3: s = 4'h8;
            4'h4: s = 4'hC;
            4'h5: s = 4'h1;
            4'h6: s = 4'h2;
            4'h7: s = 4'hD;
            4'h8: s = 4'hB;
            4'h9: s = 4'h4;
            4'hA: s = 4'h6;
            4'hB: s = 4'h3;
            4'hC: s = 4'h0;
            4'hD: s = 4'h7;
            4'hE: s = 4'h9;
            default: s = 4'hA;
        endcase
        return s;
    endfunction
`endif

endpackage

// File: rtl/present_iter_if.sv
// Request/response bundle for present_iter: valid/ready on the input side
// (block + key) and on the output side (result).
// Optional feature macro: PRESENT_DEC_EN (adds the dec request bit).
interface present_iter_if #(
    parameter int KEY_W = 80
) ();

    logic             i_valid;
    logic             i_ready;
    logic [63:0]      x;
    logic [KEY_W-1:0] k;
`ifdef PRESENT_DEC_EN
    logic             dec;
`endif
    logic             o_valid;
    logic             o_ready;
    logic [63:0]      r;

`ifdef PRESENT_DEC_EN
    modport master (
        output i_valid, x, k, dec, o_ready,
        input  i_ready, o_valid, r
    );
    modport slave (
        input  i_valid, x, k, dec, o_ready,
        output i_ready, o_valid, r
    );
`else
    modport master (
        output i_valid, x, k, o_ready,
        input  i_ready, o_valid, r
    );
    modport slave (
        input  i_valid, x, k, o_ready,
        output i_ready, o_valid, r
    );
`endif

endinterface

// File: rtl/present_key_step.sv
// One PRESENT key-schedule step, combinational. dir=0 gives the forward step
// (rotate left 61, S-box on top nibble(s), XOR round counter); dir=1 gives the
// exact inverse (undo counter XOR, inverse S-box, rotate right 61).
// Optional feature macro: PRESENT_DEC_EN (compiles in the inverse step).
module present_key_step
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       rc,
    input  logic             dir,
    output logic [KEY_W-1:0] key_n
);

    localparam int RC_LSB = rc_lsb(KEY_W);
    localparam int NTOP   = top_nibbles(KEY_W);
    localparam int LOW_W  = KEY_W - 4 * NTOP;

    genvar gi;

    // Counter XOR mask, shared by both directions since XOR is self-inverse.
    logic [KEY_W-1:0] rc_mask;
    assign rc_mask = KEY_W'(rc) << RC_LSB;

    // Forward step: rotate first, then substitute the new top nibble(s).
    logic [KEY_W-1:0] fwd_rot;
    logic [KEY_W-1:0] fwd_sub;
    logic [KEY_W-1:0] fwd_key;

    assign fwd_rot = {key[KEY_W-62:0], key[KEY_W-1:KEY_W-61]};

    generate
        for (gi = 0; gi < NTOP; gi++) begin : g_fwd_sbox
            assign fwd_sub[KEY_W-1-4*gi -: 4] = sbox(fwd_rot[KEY_W-1-4*gi -: 4]);
        end
    endgenerate
    assign fwd_sub[LOW_W-1:0] = fwd_rot[LOW_W-1:0];
    assign fwd_key = fwd_sub ^ rc_mask;

`ifdef PRESENT_DEC_EN
    // Inverse step: undo the XOR and substitution, then rotate back.
    logic [KEY_W-1:0] inv_xor;
    logic [KEY_W-1:0] inv_sub;
    logic [KEY_W-1:0] inv_key;

    assign inv_xor = key ^ rc_mask;

    generate
        for (gi = 0; gi < NTOP; gi++) begin : g_inv_sbox
            assign inv_sub[KEY_W-1-4*gi -: 4] = sbox_inv(inv_xor[KEY_W-1-4*gi -: 4]);
        end
    endgenerate
    assign inv_sub[LOW_W-1:0] = inv_xor[LOW_W-1:0];
    assign inv_key = {inv_sub[60:0], inv_sub[KEY_W-1:61]};

    assign key_n = dir ? inv_key : fwd_key;
`else
    // Encrypt-only build: the direction input has nothing to select.
    logic dir_unused;
    assign dir_unused = dir;
    assign key_n      = fwd_key;
`endif

endmodule

// File: rtl/present_iter.sv
// Iterative PRESENT block cipher: one round per clock with an on-chip key
// schedule, one block in flight, valid/ready on both sides. The result is
// registered and held until the consumer takes it.
// Optional feature macro: PRESENT_DEC_EN (decryption via EXPAND + DRUN).
module present_iter
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = PRESENT_ROUNDS
) (
    input  logic          clk,
    input  logic          rst,
    present_iter_if.slave bus
);

    generate
        if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
            $error("present_iter: KEY_W must be 80 or 128");
        end
        if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
            $error("present_iter: ROUNDS must be in 1..31");
        end
    endgenerate

    localparam logic [4:0] RC_LAST  = 5'(ROUNDS);
    localparam logic [4:0] RC_FIRST = 5'd1;

    genvar gi;

    state_t           fsm_reg,     fsm_next;
    logic [63:0]      state_reg,   state_next;
    logic [KEY_W-1:0] key_reg,     key_next;
    logic [4:0]       rc_reg,      rc_next;
    logic [63:0]      r_reg,       r_next;
    logic             o_valid_reg, o_valid_next;

    // Round-key addition is shared by encrypt rounds, decrypt rounds and FINAL.
    logic [63:0] round_key;
    logic [63:0] add_key;
    logic [63:0] sub_layer;
    logic [63:0] enc_state;

    assign round_key = key_reg[KEY_W-1 -: 64];
    assign add_key   = state_reg ^ round_key;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            assign sub_layer[4*gi +: 4] = sbox(add_key[4*gi +: 4]);
        end
        // Bit j goes to 16j mod 63; this index form also pins bit 63.
        for (gi = 0; gi < 64; gi++) begin : g_perm
            assign enc_state[(gi % 4) * 16 + gi / 4] = sub_layer[gi];
        end
    endgenerate

`ifdef PRESENT_DEC_EN
    // Decrypt round: inverse permutation then inverse S-box layer.
    logic [63:0] pinv_layer;
    logic [63:0] dec_state;

    generate
        for (gi = 0; gi < 64; gi++) begin : g_perm_inv
            assign pinv_layer[gi] = add_key[(gi % 4) * 16 + gi / 4];
        end
        for (gi = 0; gi < 16; gi++) begin : g_sbox_inv
            assign dec_state[4*gi +: 4] = sbox_inv(pinv_layer[4*gi +: 4]);
        end
    endgenerate
`endif

    // The key step runs backwards only while decrypt rounds are active.
    logic             step_dir;
    logic [KEY_W-1:0] key_stepped;

`ifdef PRESENT_DEC_EN
    assign step_dir = (fsm_reg == DRUN);
`else
    assign step_dir = 1'b0;
`endif

    present_key_step #(
        .KEY_W (KEY_W)
    ) u_key_step (
        .key   (key_reg),
        .rc    (rc_reg),
        .dir   (step_dir),
        .key_n (key_stepped)
    );

    // Next-state and datapath control; rc saturates at its terminal value.
    always_comb begin
        fsm_next     = fsm_reg;
        state_next   = state_reg;
        key_next     = key_reg;
        rc_next      = rc_reg;
        r_next       = r_reg;
        o_valid_next = o_valid_reg;

        case (fsm_reg)
            IDLE: begin
                if (bus.i_valid) begin
                    state_next = bus.x;
                    key_next   = bus.k;
                    rc_next    = RC_FIRST;
`ifdef PRESENT_DEC_EN
                    fsm_next   = bus.dec ? EXPAND : RUN;
`else
                    fsm_next   = RUN;
`endif
                end
            end
            RUN: begin
                state_next = enc_state;
                key_next   = key_stepped;
                if (rc_reg == RC_LAST) begin
                    fsm_next = FINAL;
                end else begin
                    rc_next = rc_reg + 5'd1;
                end
            end
`ifdef PRESENT_DEC_EN
            EXPAND: begin
                key_next = key_stepped;
                if (rc_reg == RC_LAST) begin
                    fsm_next = DRUN;
                end else begin
                    rc_next = rc_reg + 5'd1;
                end
            end
            DRUN: begin
                state_next = dec_state;
                key_next   = key_stepped;
                if (rc_reg == RC_FIRST) begin
                    fsm_next = FINAL;
                end else begin
                    rc_next = rc_reg - 5'd1;
                end
            end
`endif
            FINAL: begin
                r_next       = add_key;
                o_valid_next = 1'b1;
                fsm_next     = HOLD;
            end
            HOLD: begin
                if (bus.o_ready) begin
                    o_valid_next = 1'b0;
                    fsm_next     = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg     <= IDLE;
            state_reg   <= '0;
            key_reg     <= '0;
            rc_reg      <= '0;
            r_reg       <= '0;
            o_valid_reg <= 1'b0;
        end else begin
            fsm_reg     <= fsm_next;
            state_reg   <= state_next;
            key_reg     <= key_next;
            rc_reg      <= rc_next;
            r_reg       <= r_next;
            o_valid_reg <= o_valid_next;
        end
    end

    assign bus.i_ready = (fsm_reg == IDLE);
    assign bus.o_valid = o_valid_reg;
    assign bus.r       = r_reg;

endmodule

// File: tb/tb_present_iter.sv
// Testbench for present_iter: a PRESENT-80 and a PRESENT-128 instance share
// clock and reset. Known-answer vectors, random blocks against a reference
// model, backpressure/handshake and mid-operation reset sequences.
// Decrypt cases are included when PRESENT_DEC_EN is defined.
module tb_present_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    present_iter_if #(.KEY_W(80))  bus80  ();
    present_iter_if #(.KEY_W(128)) bus128 ();

    present_iter #(.KEY_W(80), .ROUNDS(31)) dut80 (
        .clk (clk),
        .rst (rst),
        .bus (bus80)
    );

    present_iter #(.KEY_W(128), .ROUNDS(31)) dut128 (
        .clk (clk),
        .rst (rst),
        .bus (bus128)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K80_ONES = {48'h0, {80{1'b1}}};
    localparam int ENC_LAT = 32;
    localparam int DEC_LAT = 63;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // Reference PRESENT encryption written straight from the cipher definition.
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key_in,
                                            input bit wide);
        logic [63:0]  s;
        logic [63:0]  p;
        logic [63:0]  rk;
        logic [127:0] k128;
        logic [79:0]  k80;
        s    = pt;
        k128 = key_in;
        k80  = key_in[79:0];
        for (int rnd = 1; rnd <= 31; rnd++) begin
            rk = wide ? k128[127:64] : k80[79:16];
            s  = s ^ rk;
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
            p = '0;
            for (int j = 0; j < 64; j++) p[(j == 63) ? 63 : (j * 16) % 63] = s[j];
            s = p;
            if (wide) begin
                k128 = (k128 << 61) | (k128 >> 67);
                k128[127:124] = SB[k128[127:124]];
                k128[123:120] = SB[k128[123:120]];
                k128[66:62]   = k128[66:62] ^ 5'(rnd);
            end else begin
                k80 = (k80 << 61) | (k80 >> 19);
                k80[79:76] = SB[k80[79:76]];
                k80[19:15] = k80[19:15] ^ 5'(rnd);
            end
        end
        rk = wide ? k128[127:64] : k80[79:16];
        return s ^ rk;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_iready(input bit wide);
        return wide ? bus128.i_ready : bus80.i_ready;
    endfunction

    function automatic logic get_ovalid(input bit wide);
        return wide ? bus128.o_valid : bus80.o_valid;
    endfunction

    function automatic logic [63:0] get_r(input bit wide);
        return wide ? bus128.r : bus80.r;
    endfunction

    task automatic set_req(input bit wide, input logic v, input logic [63:0] xv,
                           input logic [127:0] kv, input logic dv);
        if (wide) begin
            bus128.i_valid = v;
            bus128.x       = xv;
            bus128.k       = kv;
`ifdef PRESENT_DEC_EN
            bus128.dec     = dv;
`endif
        end else begin
            bus80.i_valid = v;
            bus80.x       = xv;
            bus80.k       = kv[79:0];
`ifdef PRESENT_DEC_EN
            bus80.dec     = dv;
`endif
        end
        if (v && dv && 0) $display("unreachable");
    endtask

    task automatic set_oready(input bit wide, input logic v);
        if (wide) bus128.o_ready = v;
        else      bus80.o_ready  = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Submit one block and wait (bounded) for the result; o_ready stays low.
    task automatic run_txn(input bit wide, input logic [63:0] xv, input logic [127:0] kv,
                           input logic dv, output logic [63:0] rv, output int lat);
        int waitc = 0;
        while (!get_iready(wide) && waitc < 200) begin
            step();
            waitc++;
        end
        if (!get_iready(wide)) begin
            checks++;
            errors++;
            $display("FAIL i_ready_timeout: got i_ready=0 after %0d cycles, expected 1", waitc);
        end
        set_req(wide, 1'b1, xv, kv, dv);
        step();
        set_req(wide, 1'b0, 64'h0, 128'h0, 1'b0);
        lat = 0;
        while (!get_ovalid(wide) && lat < 200) begin
            step();
            lat++;
        end
        rv = get_r(wide);
        $display("txn key%0d dec=%0d x=%h r=%h lat=%0d", wide ? 128 : 80, dv, xv, rv, lat);
    endtask

    // Consume the held result and check the handshake return to idle.
    task automatic release_out(input bit wide, input string tag);
        set_oready(wide, 1'b1);
        step();
        set_oready(wide, 1'b0);
        check_int({tag, "_ovalid_drop"}, int'(get_ovalid(wide)), 0);
        check_int({tag, "_iready_rise"}, int'(get_iready(wide)), 1);
    endtask

    typedef struct {
        bit           wide;
        bit           dec;
        logic [63:0]  x;
        logic [127:0] k;
        logic [63:0]  exp_r;
        int           exp_lat;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]  rv;
        logic [63:0]  held;
        logic [63:0]  pt;
        logic [63:0]  ct;
        logic [127:0] kv;
        int           lat;
        bit           wide;
        bit           seen_valid;

        set_req(1'b0, 1'b0, 64'h0, 128'h0, 1'b0);
        set_req(1'b1, 1'b0, 64'h0, 128'h0, 1'b0);
        set_oready(1'b0, 1'b0);
        set_oready(1'b1, 1'b0);

        vecs.push_back('{1'b0, 1'b0, 64'h0, 128'h0, 64'h5579C1387B228445, ENC_LAT});
        vecs.push_back('{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, K80_ONES, 64'h3333DCD3213210D2, ENC_LAT});
        vecs.push_back('{1'b0, 1'b0, 64'h0, K80_ONES, 64'hE72C46C0F5945049, ENC_LAT});
        vecs.push_back('{1'b1, 1'b0, 64'h0, 128'h0, 64'h96DB702A2E6900AF, ENC_LAT});
`ifdef PRESENT_DEC_EN
        vecs.push_back('{1'b0, 1'b1, 64'hE72C46C0F5945049, K80_ONES, 64'h0, DEC_LAT});
        vecs.push_back('{1'b1, 1'b1, 64'h96DB702A2E6900AF, 128'h0, 64'h0, DEC_LAT});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check_int("rst_iready80", int'(bus80.i_ready), 1);
        check_int("rst_ovalid80", int'(bus80.o_valid), 0);
        check64("rst_r80", bus80.r, 64'h0);
        check_int("rst_iready128", int'(bus128.i_ready), 1);
        check_int("rst_ovalid128", int'(bus128.o_valid), 0);

        // Known-answer table.
        foreach (vecs[i]) begin
            run_txn(vecs[i].wide, vecs[i].x, vecs[i].k, vecs[i].dec, rv, lat);
            check64($sformatf("kat%0d_r", i), rv, vecs[i].exp_r);
            check_int($sformatf("kat%0d_lat", i), lat, vecs[i].exp_lat);
            release_out(vecs[i].wide, $sformatf("kat%0d", i));
        end

        // Random encryptions against the reference model.
        for (int i = 0; i < 8; i++) begin
            wide = (i % 2) == 1;
            pt   = {$urandom, $urandom};
            kv   = {$urandom, $urandom, $urandom, $urandom};
            if (!wide) kv[127:80] = '0;
            run_txn(wide, pt, kv, 1'b0, rv, lat);
            check64($sformatf("rnd_enc%0d_r", i), rv, ref_enc(pt, kv, wide));
            check_int($sformatf("rnd_enc%0d_lat", i), lat, ENC_LAT);
            release_out(wide, $sformatf("rnd_enc%0d", i));
        end

`ifdef PRESENT_DEC_EN
        // Random decryptions: deciphering the model's ciphertext yields the plaintext.
        for (int i = 0; i < 4; i++) begin
            wide = (i % 2) == 1;
            pt   = {$urandom, $urandom};
            kv   = {$urandom, $urandom, $urandom, $urandom};
            if (!wide) kv[127:80] = '0;
            ct = ref_enc(pt, kv, wide);
            run_txn(wide, ct, kv, 1'b1, rv, lat);
            check64($sformatf("rnd_dec%0d_r", i), rv, pt);
            check_int($sformatf("rnd_dec%0d_lat", i), lat, DEC_LAT);
            release_out(wide, $sformatf("rnd_dec%0d", i));
        end
`endif

        // Busy requests ignored, then backpressure in HOLD.
        set_req(1'b0, 1'b1, 64'h0, 128'h0, 1'b0);
        step();
        set_req(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, K80_ONES, 1'b0);
        lat = 0;
        while (!bus80.o_valid && lat < 200) begin
            step();
            lat++;
        end
        $display("txn key80 busy-request x=0 r=%h lat=%0d", bus80.r, lat);
        check64("bp_r", bus80.r, 64'h5579C1387B228445);
        check_int("bp_lat", lat, ENC_LAT);
        held = 64'h5579C1387B228445;
        for (int c = 0; c < 10; c++) begin
            step();
            check64($sformatf("bp_hold%0d_r", c), bus80.r, held);
            check_int($sformatf("bp_hold%0d_iready", c), int'(bus80.i_ready), 0);
            check_int($sformatf("bp_hold%0d_ovalid", c), int'(bus80.o_valid), 1);
        end
        set_req(1'b0, 1'b0, 64'h0, 128'h0, 1'b0);
        release_out(1'b0, "bp");

        // Reset in the middle of a block.
        set_req(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, K80_ONES, 1'b0);
        step();
        set_req(1'b0, 1'b0, 64'h0, 128'h0, 1'b0);
        repeat (14) step();
        check_int("mid_busy_iready", int'(bus80.i_ready), 0);
        rst = 1'b1;
        #1;
        check_int("mid_rst_ovalid", int'(bus80.o_valid), 0);
        step();
        rst = 1'b0;
        step();
        check_int("mid_rel_iready", int'(bus80.i_ready), 1);
        check_int("mid_rel_ovalid", int'(bus80.o_valid), 0);
        check64("mid_rel_r", bus80.r, 64'h0);
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus80.o_valid) seen_valid = 1'b1;
        end
        check_int("mid_no_output", int'(seen_valid), 0);
        run_txn(1'b0, 64'h0, 128'h0, 1'b0, rv, lat);
        check64("mid_fresh_r", rv, 64'h5579C1387B228445);
        check_int("mid_fresh_lat", lat, ENC_LAT);
        release_out(1'b0, "mid_fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
